// File: rtl/soc_system_cc_capture.sv
// soc_system_cc_capture: measures the clk-cycle period between rising edges of
// an asynchronous input and publishes it to the HPS-visible cc_out PIO word.
// A missing edge publishes an all-ones sentinel and sets a sticky timeout flag.
// Optional feature macro: CC_CAPTURE_DEGLITCH_EN adds a FILTER_LEN-cycle
// stability filter between the synchronizer and the edge detector.
module soc_system_cc_capture #(
  parameter int          WIDTH          = 32,
  parameter int          SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int          FILTER_LEN     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] cc_out,
  output logic             cc_valid,
  output logic             cc_timeout,
  output logic             cc_busy
);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TIMEOUT_VAL = WIDTH'(TIMEOUT_CYCLES);
  // The warm-up counter runs until both the synchronizer and the prev flop
  // hold real samples of sig_in, so a level present at reset release is not
  // mistaken for an edge.
  localparam int               WARM_W      = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_DONE  = WARM_W'(SYNC_STAGES + 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 1) begin : g_param_check
    $error("soc_system_cc_capture: SYNC_STAGES must be 2..4 and FILTER_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [WARM_W-1:0]      warm_q;
  logic                   prev_q;
  logic                   sync_last;
  logic                   primed;
  logic                   level;
  logic                   rise;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cc_out_q, cc_out_d;
  logic             cc_valid_q, cc_valid_d;
  logic             cc_timeout_q, cc_timeout_d;
  logic             cc_busy_q, cc_busy_d;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign primed    = (warm_q == WARM_DONE);

  // Shift sig_in through the synchronizer chain and count off the warm-up cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      if (!primed) warm_q <= warm_q + 1'b1;
    end
  end

`ifdef CC_CAPTURE_DEGLITCH_EN
  localparam int               STAB_W   = $clog2(FILTER_LEN + 1);
  localparam logic [STAB_W-1:0] STAB_END = STAB_W'(FILTER_LEN - 1);

  logic              filt_q;
  logic [STAB_W-1:0] stab_q;

  // Accept a new level only after it has differed from the filtered level for
  // FILTER_LEN consecutive cycles; before warm-up the filter just follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else if (!primed) begin
      filt_q <= sync_last;
      stab_q <= '0;
    end else if (sync_last == filt_q) begin
      stab_q <= '0;
    end else if (stab_q == STAB_END) begin
      filt_q <= sync_last;
      stab_q <= '0;
    end else begin
      stab_q <= stab_q + 1'b1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_last;
`endif

  // Remember the previous level for edge detection; during warm-up it tracks
  // the raw synchronizer output so the first primed cycle sees a settled value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= primed ? level : sync_last;
  end

  assign rise = primed & level & ~prev_q;

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      cc_out_q     <= '0;
      cc_valid_q   <= 1'b0;
      cc_timeout_q <= 1'b0;
      cc_busy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      cc_out_q     <= cc_out_d;
      cc_valid_q   <= cc_valid_d;
      cc_timeout_q <= cc_timeout_d;
      cc_busy_q    <= cc_busy_d;
    end
  end

  // Next-state logic: disable beats a rise, and a rise beats the timeout, so
  // an edge landing on the timeout cycle still publishes a normal period.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    cc_out_d     = cc_out_q;
    cc_valid_d   = 1'b0;
    cc_timeout_d = cc_timeout_q;
    if (!enable) cc_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (enable) state_d = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          state_d = IDLE;
          count_d = '0;
        end else if (rise) begin
          state_d = MEASURE;
          count_d = ONE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_d = IDLE;
          count_d = '0;
        end else if (rise) begin
          cc_out_d     = count_q;
          cc_valid_d   = 1'b1;
          cc_timeout_d = 1'b0;
          count_d      = ONE;
        end else if (count_q == TIMEOUT_VAL) begin
          cc_out_d     = '1;
          cc_valid_d   = 1'b1;
          cc_timeout_d = 1'b1;
          state_d      = ARMED;
          count_d      = '0;
        end else begin
          count_d = count_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    cc_busy_d = (state_d != IDLE);
  end

  assign cc_out     = cc_out_q;
  assign cc_valid   = cc_valid_q;
  assign cc_timeout = cc_timeout_q;
  assign cc_busy    = cc_busy_q;

endmodule

// File: tb/tb_soc_system_cc_capture.sv
// Testbench for soc_system_cc_capture. A timestamp-based reference model
// predicts every output on every cycle from the edges the bench drives.
module tb_soc_system_cc_capture;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int TMO   = 100;
  localparam int FLT   = 4;
`ifdef CC_CAPTURE_DEGLITCH_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif
  // Drive-to-cc_valid latency of a clean rising edge.
  localparam int LAT       = SYNC + 1 + (FILT_ON ? FLT : 0);
  // Latency from the model's rise marker to the publishing edge.
  localparam int RL        = FILT_ON ? SYNC + 2 : SYNC + 1;
  localparam int SHORT_LOW = FILT_ON ? 5 : 2;
  localparam int MAXP      = 8192;
  localparam int M_IDLE = 0, M_ARMED = 1, M_MEAS = 2;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             sig_in;
  logic [WIDTH-1:0] cc_out;
  logic             cc_valid;
  logic             cc_timeout;
  logic             cc_busy;

  int checks;
  int bad;

  bit drv [MAXP];
  bit enH [MAXP];
  bit rm  [MAXP];
  int p;
  int mode;
  int start;
  bit [WIDTH-1:0] mOut;
  bit mTo;
  bit fcur;
  int run;

  logic             expValid;
  logic [WIDTH-1:0] expOut;
  logic             expTo;
  logic             expBusy;

  bit pat [$];
  bit enp [$];

  soc_system_cc_capture #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .cc_out(cc_out), .cc_valid(cc_valid), .cc_timeout(cc_timeout), .cc_busy(cc_busy)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function void addRun(input bit lvl, input int len, input bit en);
    for (int i = 0; i < len; i++) begin
      pat.push_back(lvl);
      enp.push_back(en);
    end
  endfunction

  function void addSquare(input int hi, input int lo, input int n, input bit en);
    for (int k = 0; k < n; k++) begin
      addRun(1'b1, hi, en);
      addRun(1'b0, lo, en);
    end
  endfunction

  // Restart the model at reset release; the current inputs are history point 0.
  task automatic reset_model();
    p     = 0;
    mode  = M_IDLE;
    start = 0;
    mOut  = '0;
    mTo   = 1'b0;
    drv[0] = sig_in;
    enH[0] = enable;
    rm[0]  = 1'b0;
    fcur  = sig_in;
    run   = 0;
  endtask

  // Advance one clock: predict outputs after the edge, then drive the next inputs.
  task automatic advance(input bit s, input bit e);
    bit r;
    bit en;
    @(posedge clk);
    #1;
    p++;
    if (p >= MAXP - 1) begin
      $display("[TB] FAIL model_capacity p=%0d limit=%0d", p, MAXP);
      $fatal(1, "[TB] model history exhausted");
    end
    en = enH[p-1];
    r  = (p - RL >= 0) ? rm[p-RL] : 1'b0;
    expValid = 1'b0;
    if (!en) begin
      mode = M_IDLE;
      mTo  = 1'b0;
    end else if (mode == M_IDLE) begin
      mode = M_ARMED;
    end else if (r) begin
      if (mode == M_ARMED) begin
        mode  = M_MEAS;
        start = p;
      end else begin
        mOut     = WIDTH'(p - start);
        expValid = 1'b1;
        mTo      = 1'b0;
        start    = p;
      end
    end else if (mode == M_MEAS && p - start == TMO) begin
      mOut     = '1;
      expValid = 1'b1;
      mTo      = 1'b1;
      mode     = M_ARMED;
    end
    expOut  = mOut;
    expTo   = mTo;
    expBusy = (mode != M_IDLE);
    sig_in = s;
    enable = e;
    drv[p] = s;
    enH[p] = e;
    rm[p]  = 1'b0;
    if (FILT_ON) begin
      if (s != fcur) begin
        run++;
        if (run == FLT) begin
          fcur  = s;
          run   = 0;
          rm[p] = s;
        end
      end else begin
        run = 0;
      end
    end else begin
      rm[p] = s && !drv[p-1];
    end
  endtask

  // Reset with sig_in toggling must hold every output at zero.
  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      sig_in = 1'($urandom);
      enable = 1'($urandom);
      checks++;
      if ({cc_valid, cc_out, cc_timeout, cc_busy} !== {1'b0, {WIDTH{1'b0}}, 1'b0, 1'b0}) begin
        bad++;
        $display("[TB] FAIL reset_hold got valid=%0b out=%h to=%0b busy=%0b want all zero",
                 cc_valid, cc_out, cc_timeout, cc_busy);
      end
    end
    sig_in = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_model();
    pat.delete();
    enp.delete();
    addRun(1'b0, 8, 1'b0);
    for (int i = 0; i < pat.size(); i++) begin
      advance(pat[i], enp[i]);
      checks++;
      if ({cc_valid, cc_out, cc_timeout, cc_busy} !== {expValid, expOut, expTo, expBusy}) begin
        bad++;
        $display("[TB] FAIL reset_idle p=%0d got v=%0b out=%h to=%0b busy=%0b want v=%0b out=%h to=%0b busy=%0b",
                 p, cc_valid, cc_out, cc_timeout, cc_busy, expValid, expOut, expTo, expBusy);
      end
    end
  endtask

  // Period-10 square wave: first rise arms, later rises publish 10 after LAT cycles.
  task automatic test_period();
    int risePt;
    int nValid;
    bit prevS;
    risePt = 0;
    nValid = 0;
    prevS  = 1'b0;
    pat.delete();
    enp.delete();
    addRun(1'b0, 2, 1'b1);
    addSquare(5, 5, 6, 1'b1);
    for (int i = 0; i < pat.size(); i++) begin
      advance(pat[i], enp[i]);
      checks++;
      if ({cc_valid, cc_out, cc_timeout, cc_busy} !== {expValid, expOut, expTo, expBusy}) begin
        bad++;
        $display("[TB] FAIL period p=%0d got v=%0b out=%h to=%0b busy=%0b want v=%0b out=%h to=%0b busy=%0b",
                 p, cc_valid, cc_out, cc_timeout, cc_busy, expValid, expOut, expTo, expBusy);
      end
      if (cc_valid === 1'b1) begin
        nValid++;
        checks++;
        if (p - risePt != LAT) begin
          bad++;
          $display("[TB] FAIL period_latency got=%0d want=%0d", p - risePt, LAT);
        end
      end
      if (pat[i] && !prevS) risePt = p;
      prevS = pat[i];
    end
    checks++;
    if (nValid != 5) begin
      bad++;
      $display("[TB] FAIL period_count got=%0d want=5", nValid);
    end
    checks++;
    if (cc_out !== 32'd10) begin
      bad++;
      $display("[TB] FAIL period_value got=%0d want=10", cc_out);
    end
  endtask

  // Missing edge publishes the sentinel; the next rise re-arms, the one after publishes.
  task automatic test_timeout();
    bit saw;
    saw = 1'b0;
    pat.delete();
    enp.delete();
    addRun(1'b1, 5, 1'b1);
    addRun(1'b0, 150, 1'b1);
    addRun(1'b1, 5, 1'b1);
    addRun(1'b0, SHORT_LOW, 1'b1);
    addRun(1'b1, 5, 1'b1);
    addRun(1'b0, 8, 1'b1);
    for (int i = 0; i < pat.size(); i++) begin
      advance(pat[i], enp[i]);
      checks++;
      if ({cc_valid, cc_out, cc_timeout, cc_busy} !== {expValid, expOut, expTo, expBusy}) begin
        bad++;
        $display("[TB] FAIL timeout p=%0d got v=%0b out=%h to=%0b busy=%0b want v=%0b out=%h to=%0b busy=%0b",
                 p, cc_valid, cc_out, cc_timeout, cc_busy, expValid, expOut, expTo, expBusy);
      end
      if (cc_valid === 1'b1 && cc_out === '1 && cc_timeout === 1'b1) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b1) begin
      bad++;
      $display("[TB] FAIL timeout_sentinel got=%0b want=1", saw);
    end
    checks++;
    if (cc_out !== 32'(5 + SHORT_LOW) || cc_timeout !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_recover got out=%0d to=%0b want out=%0d to=0",
               cc_out, cc_timeout, 5 + SHORT_LOW);
    end
  endtask

  // A rise exactly on the timeout count publishes the count, not the sentinel.
  task automatic test_collision();
    bit saw;
    saw = 1'b0;
    pat.delete();
    enp.delete();
    addRun(1'b1, 5, 1'b1);
    addRun(1'b0, TMO - 5, 1'b1);
    addRun(1'b1, 5, 1'b1);
    addRun(1'b0, 12, 1'b1);
    for (int i = 0; i < pat.size(); i++) begin
      advance(pat[i], enp[i]);
      checks++;
      if ({cc_valid, cc_out, cc_timeout, cc_busy} !== {expValid, expOut, expTo, expBusy}) begin
        bad++;
        $display("[TB] FAIL collision p=%0d got v=%0b out=%h to=%0b busy=%0b want v=%0b out=%h to=%0b busy=%0b",
                 p, cc_valid, cc_out, cc_timeout, cc_busy, expValid, expOut, expTo, expBusy);
      end
      if (cc_timeout === 1'b1) saw = 1'b1;
    end
    checks++;
    if (cc_out !== 32'(TMO) || saw !== 1'b0) begin
      bad++;
      $display("[TB] FAIL collision_value got out=%0d sawTimeout=%0b want out=%0d sawTimeout=0",
               cc_out, saw, TMO);
    end
  endtask

  // Disable mid-measure: IDLE, result held; after re-enable the first rise only arms.
  task automatic test_disable();
    int offValid;
    int reValid;
    offValid = 0;
    reValid  = 0;
    pat.delete();
    enp.delete();
    addSquare(5, 5, 3, 1'b1);
    addRun(1'b1, 5, 1'b1);
    addRun(1'b0, 3, 1'b1);
    addSquare(5, 5, 2, 1'b0);
    for (int i = 0; i < pat.size(); i++) begin
      advance(pat[i], enp[i]);
      checks++;
      if ({cc_valid, cc_out, cc_timeout, cc_busy} !== {expValid, expOut, expTo, expBusy}) begin
        bad++;
        $display("[TB] FAIL disable p=%0d got v=%0b out=%h to=%0b busy=%0b want v=%0b out=%h to=%0b busy=%0b",
                 p, cc_valid, cc_out, cc_timeout, cc_busy, expValid, expOut, expTo, expBusy);
      end
      if (i >= 38 && cc_valid === 1'b1) offValid++;
    end
    checks++;
    if (cc_out !== 32'd10 || cc_busy !== 1'b0 || offValid != 0) begin
      bad++;
      $display("[TB] FAIL disable_hold got out=%0d busy=%0b pulses=%0d want out=10 busy=0 pulses=0",
               cc_out, cc_busy, offValid);
    end
    pat.delete();
    enp.delete();
    addSquare(5, 5, 4, 1'b1);
    addRun(1'b0, 8, 1'b1);
    for (int i = 0; i < pat.size(); i++) begin
      advance(pat[i], enp[i]);
      checks++;
      if ({cc_valid, cc_out, cc_timeout, cc_busy} !== {expValid, expOut, expTo, expBusy}) begin
        bad++;
        $display("[TB] FAIL reenable p=%0d got v=%0b out=%h to=%0b busy=%0b want v=%0b out=%h to=%0b busy=%0b",
                 p, cc_valid, cc_out, cc_timeout, cc_busy, expValid, expOut, expTo, expBusy);
      end
      if (cc_valid === 1'b1) reValid++;
    end
    checks++;
    if (reValid != 3) begin
      bad++;
      $display("[TB] FAIL reenable_count got=%0d want=3", reValid);
    end
  endtask

  // Two-cycle glitch inside a period-20 waveform.
  task automatic test_glitch();
    pat.delete();
    enp.delete();
    for (int k = 0; k < 4; k++) begin
      addRun(1'b1, 5, 1'b1);
      addRun(1'b0, 5, 1'b1);
      addRun(1'b1, 2, 1'b1);
      addRun(1'b0, 8, 1'b1);
    end
    addRun(1'b1, 5, 1'b1);
    addRun(1'b0, 12, 1'b1);
    for (int i = 0; i < pat.size(); i++) begin
      advance(pat[i], enp[i]);
      checks++;
      if ({cc_valid, cc_out, cc_timeout, cc_busy} !== {expValid, expOut, expTo, expBusy}) begin
        bad++;
        $display("[TB] FAIL glitch p=%0d got v=%0b out=%h to=%0b busy=%0b want v=%0b out=%h to=%0b busy=%0b",
                 p, cc_valid, cc_out, cc_timeout, cc_busy, expValid, expOut, expTo, expBusy);
      end
    end
    checks++;
    if (cc_out !== (FILT_ON ? 32'd20 : 32'd10)) begin
      bad++;
      $display("[TB] FAIL glitch_value got=%0d want=%0d", cc_out, FILT_ON ? 20 : 10);
    end
  endtask

  // Random run lengths and occasional enable flips against the model.
  task automatic test_random();
    bit lvl;
    bit en;
    lvl = 1'b0;
    en  = 1'b1;
    pat.delete();
    enp.delete();
    while (pat.size() < 2000) begin
      lvl = ~lvl;
      if ($urandom_range(0, 19) == 0) en = ~en;
      addRun(lvl, $urandom_range(1, 30), en);
    end
    for (int i = 0; i < pat.size(); i++) begin
      advance(pat[i], enp[i]);
      checks++;
      if ({cc_valid, cc_out, cc_timeout, cc_busy} !== {expValid, expOut, expTo, expBusy}) begin
        bad++;
        $display("[TB] FAIL random p=%0d got v=%0b out=%h to=%0b busy=%0b want v=%0b out=%h to=%0b busy=%0b",
                 p, cc_valid, cc_out, cc_timeout, cc_busy, expValid, expOut, expTo, expBusy);
      end
    end
  endtask

  // Async reset mid-measure clears everything; a high level at release is not an edge.
  task automatic test_reset_mid();
    pat.delete();
    enp.delete();
    addSquare(5, 5, 3, 1'b1);
    addRun(1'b1, 4, 1'b1);
    for (int i = 0; i < pat.size(); i++) begin
      advance(pat[i], enp[i]);
      checks++;
      if ({cc_valid, cc_out, cc_timeout, cc_busy} !== {expValid, expOut, expTo, expBusy}) begin
        bad++;
        $display("[TB] FAIL premid p=%0d got v=%0b out=%h to=%0b busy=%0b want v=%0b out=%h to=%0b busy=%0b",
                 p, cc_valid, cc_out, cc_timeout, cc_busy, expValid, expOut, expTo, expBusy);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({cc_valid, cc_out, cc_timeout, cc_busy} !== {1'b0, {WIDTH{1'b0}}, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_mid got valid=%0b out=%h to=%0b busy=%0b want all zero",
               cc_valid, cc_out, cc_timeout, cc_busy);
    end
    sig_in = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_model();
    pat.delete();
    enp.delete();
    addRun(1'b1, 6, 1'b1);
    for (int k = 0; k < 3; k++) begin
      addRun(1'b0, 6, 1'b1);
      addRun(1'b1, 6, 1'b1);
    end
    addRun(1'b0, 10, 1'b1);
    for (int i = 0; i < pat.size(); i++) begin
      advance(pat[i], enp[i]);
      checks++;
      if ({cc_valid, cc_out, cc_timeout, cc_busy} !== {expValid, expOut, expTo, expBusy}) begin
        bad++;
        $display("[TB] FAIL postmid p=%0d got v=%0b out=%h to=%0b busy=%0b want v=%0b out=%h to=%0b busy=%0b",
                 p, cc_valid, cc_out, cc_timeout, cc_busy, expValid, expOut, expTo, expBusy);
      end
    end
    checks++;
    if (cc_out !== 32'd12) begin
      bad++;
      $display("[TB] FAIL postmid_value got=%0d want=12", cc_out);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks = 0;
    bad    = 0;
    reset  = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    test_reset();
    test_period();
    test_timeout();
    test_collision();
    test_disable();
    test_glitch();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
